// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source one-entry buffers, fixed priority load > FPU > ALU, registered RF write port.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN (uses STARVE_LIMIT).
module wb_arbiter #(
    parameter int unsigned NSRC         = 3,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [5*NSRC-1:0]    src_rd,
    input  logic [NSRC-1:0]      src_f,
    input  logic [32*NSRC-1:0]   src_data,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic                 wb_f,
    output logic [31:0]          wb_data,
    output logic                 wb_busy
);

    logic [NSRC-1:0] buf_valid_q, buf_valid_d;
    logic [4:0]      buf_rd_q   [NSRC];
    logic [4:0]      buf_rd_d   [NSRC];
    logic            buf_f_q    [NSRC];
    logic            buf_f_d    [NSRC];
    logic [31:0]     buf_data_q [NSRC];
    logic [31:0]     buf_data_d [NSRC];

    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_f_q, wb_f_d;
    logic [31:0]     wb_data_q, wb_data_d;

    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] accept;
    logic            found;

`ifdef WB_STARVE_GUARD_EN
    logic [3:0]      wait_q [NSRC];
    logic [3:0]      wait_d [NSRC];
`endif

    // Starved buffers (if the guard is built in) preempt plain fixed priority.
    always_comb begin
        grant = '0;
        found = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!found && buf_valid_q[i] && (wait_q[i] >= 4'(STARVE_LIMIT))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!found && buf_valid_q[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign src_ready = ~buf_valid_q | grant;
    assign accept    = src_valid & src_ready;

    always_comb begin
        buf_valid_d = buf_valid_q;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_f_d      = wb_f_q;
        wb_data_d   = wb_data_q;
        for (int unsigned i = 0; i < NSRC; i++) begin
            buf_rd_d[i]   = buf_rd_q[i];
            buf_f_d[i]    = buf_f_q[i];
            buf_data_d[i] = buf_data_q[i];
`ifdef WB_STARVE_GUARD_EN
            wait_d[i]     = wait_q[i];
            if (grant[i])
                wait_d[i] = '0;
            else if (buf_valid_q[i] && (wait_q[i] != 4'hF))
                wait_d[i] = wait_q[i] + 4'd1;
`endif
            // Integer x0 results are consumed but never occupy the buffer.
            if (accept[i]) begin
                buf_valid_d[i] = src_f[i] | (|src_rd[5*i +: 5]);
                buf_rd_d[i]    = src_rd[5*i +: 5];
                buf_f_d[i]     = src_f[i];
                buf_data_d[i]  = src_data[32*i +: 32];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
            if (grant[i]) begin
                wb_we_d   = 1'b1;
                wb_rd_d   = buf_rd_q[i];
                wb_f_d    = buf_f_q[i];
                wb_data_d = buf_data_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_f_q      <= 1'b0;
            wb_data_q   <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                buf_rd_q[i]   <= '0;
                buf_f_q[i]    <= 1'b0;
                buf_data_q[i] <= '0;
`ifdef WB_STARVE_GUARD_EN
                wait_q[i]     <= '0;
`endif
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_f_q      <= wb_f_d;
            wb_data_q   <= wb_data_d;
            for (int unsigned i = 0; i < NSRC; i++) begin
                buf_rd_q[i]   <= buf_rd_d[i];
                buf_f_q[i]    <= buf_f_d[i];
                buf_data_q[i] <= buf_data_d[i];
`ifdef WB_STARVE_GUARD_EN
                wait_q[i]     <= wait_d[i];
`endif
            end
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_f    = wb_f_q;
    assign wb_data = wb_data_q;
    assign wb_busy = |buf_valid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; starvation section follows WB_STARVE_GUARD_EN.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [2:0]  src_f;
    logic [95:0] src_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        wb_f;
    logic [31:0] wb_data;
    logic        wb_busy;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.NSRC(3), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_f     (src_f),
        .src_data  (src_data),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_f      (wb_f),
        .wb_data   (wb_data),
        .wb_busy   (wb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [4:0] rd, input logic f, input logic [31:0] data);
        src_valid[idx]         = 1'b1;
        src_rd[5*idx +: 5]     = rd;
        src_f[idx]             = f;
        src_data[32*idx +: 32] = data;
    endtask

    task automatic check_wb(input string tag, input logic [4:0] rd, input logic f, input logic [31:0] data);
        check({tag, "_we"}, {31'd0, wb_we}, 32'd1);
        check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        check({tag, "_f"}, {31'd0, wb_f}, {31'd0, f});
        check({tag, "_data"}, wb_data, data);
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_rd    = '0;
        src_f     = '0;
        src_data  = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_we", {31'd0, wb_we}, 32'd0);
        check("rst_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_f", {31'd0, wb_f}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_ready", {29'd0, src_ready}, 32'd7);
        check("rst_busy", {31'd0, wb_busy}, 32'd0);

        // single ALU result
        drive(2, 5'd5, 1'b0, 32'h1234);
        step();
        src_valid = '0;
        check("alu_busy", {31'd0, wb_busy}, 32'd1);
        check("alu_we0", {31'd0, wb_we}, 32'd0);
        step();
        check_wb("alu", 5'd5, 1'b0, 32'h1234);
        check("alu_busy_clr", {31'd0, wb_busy}, 32'd0);
        step();
        check("alu_we_off", {31'd0, wb_we}, 32'd0);
        check("alu_hold_data", wb_data, 32'h1234);

        // three simultaneous handshakes
        drive(0, 5'd1, 1'b0, 32'hA);
        drive(1, 5'd2, 1'b1, 32'hB);
        drive(2, 5'd3, 1'b0, 32'hC);
        step();
        src_valid = '0;
        check("tri_ready0", {29'd0, src_ready}, 32'b001);
        step();
        check_wb("tri_load", 5'd1, 1'b0, 32'hA);
        check("tri_ready1", {29'd0, src_ready}, 32'b011);
        step();
        check_wb("tri_fpu", 5'd2, 1'b1, 32'hB);
        check("tri_ready2", {29'd0, src_ready}, 32'b111);
        step();
        check_wb("tri_alu", 5'd3, 1'b0, 32'hC);
        step();
        check("tri_we_off", {31'd0, wb_we}, 32'd0);

        // x0 integer write dropped, f0 float write kept
        drive(2, 5'd0, 1'b0, 32'hFFFF);
        step();
        src_valid = '0;
        check("x0_busy", {31'd0, wb_busy}, 32'd0);
        check("x0_we_a", {31'd0, wb_we}, 32'd0);
        step();
        check("x0_we_b", {31'd0, wb_we}, 32'd0);
        drive(1, 5'd0, 1'b1, 32'h55);
        step();
        src_valid = '0;
        step();
        check_wb("f0", 5'd0, 1'b1, 32'h55);

        // ALU back-to-back stream
        for (int k = 1; k <= 6; k++) begin
            drive(2, 5'(k + 10), 1'b0, 32'(k));
            check($sformatf("stream_ready%0d", k), {31'd0, src_ready[2]}, 32'd1);
            step();
            if (k > 1) check_wb($sformatf("stream%0d", k - 1), 5'(k + 9), 1'b0, 32'(k - 1));
        end
        src_valid = '0;
        step();
        check_wb("stream6", 5'd16, 1'b0, 32'd6);
        step();
        check("stream_we_off", {31'd0, wb_we}, 32'd0);

        // reset discards pending results
        drive(0, 5'd9, 1'b0, 32'h99);
        drive(2, 5'd10, 1'b0, 32'hAA);
        step();
        src_valid = '0;
        check("prst_busy", {31'd0, wb_busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_we", {31'd0, wb_we}, 32'd0);
        check("mrst_busy", {31'd0, wb_busy}, 32'd0);
        check("mrst_ready", {29'd0, src_ready}, 32'd7);
        step();
        check("mrst_we_a", {31'd0, wb_we}, 32'd0);
        step();
        check("mrst_we_b", {31'd0, wb_we}, 32'd0);

        // continuous load traffic against one pending ALU result
        drive(0, 5'd8, 1'b0, 32'h80);
        drive(2, 5'd7, 1'b0, 32'h77);
        step();
        src_valid[2] = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k < 9) check_wb($sformatf("starve_load%0d", k), 5'd8, 1'b0, 32'h80);
            else       check_wb("starve_alu", 5'd7, 1'b0, 32'h77);
        end
        step();
        check_wb("starve_after", 5'd8, 1'b0, 32'h80);
        src_valid = '0;
        step();
        step();
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("nostarve_rd%0d", k), {27'd0, wb_rd}, 32'd8);
        end
        src_valid = '0;
        step();
        check_wb("nostarve_lastload", 5'd8, 1'b0, 32'h80);
        step();
        check_wb("nostarve_alu", 5'd7, 1'b0, 32'h77);
`endif
        step();
        check("final_busy", {31'd0, wb_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter that merges results from the ALU, FPU and load unit onto the single write port of the integer/float register file.
- Each source gets a one-entry holding buffer, so a producer can retire its result even while it loses arbitration.
- One buffered result is granted per cycle.
- Outputs are registered and drive RegWrite/WriteReg/WriteData/writef of the register file directly.

Parameters:
- NSRC, 3, number of result sources; fixed order: 0 = load, 1 = FPU, 2 = ALU.
- STARVE_LIMIT, 8, cycles a pending buffer may lose arbitration before forced grant (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- src_valid  input  NSRC  per-source result valid.
- src_ready  output  NSRC  per-source accept; handshake when valid & ready at a rising edge.
- src_rd  input  5*NSRC  per-source destination register number.
- src_f  input  NSRC  per-source destination is the float file.
- src_data  input  32*NSRC  per-source result value.
- wb_we  output  1  to register-file RegWrite.
- wb_rd  output  5  to register-file WriteReg.
- wb_f  output  1  to register-file writef.
- wb_data  output  32  to register-file WriteData.
- wb_busy  output  1  any holding buffer occupied.

Behaviour:
- Reset (clk, rst synchronous active-high): all buffers invalid. wb_we=0, wb_rd=0, wb_f=0, wb_data=0, src_ready=all 1 from the cycle after the reset edge. Reset mid-operation discards all pending results; no write is issued for them.
- Buffer i fields: valid, rd, f, data.
- src_ready[i] = ~buf_valid[i] | grant[i]. Purely combinational from state; never depends on src_valid.
- Accept: on handshake, the buffer loads rd/f/data and is valid from the next cycle.
  - Integer writes to x0 (src_f=0, src_rd=0) are accepted but dropped: buffer stays/becomes invalid and no write is produced.
  - Float f0 writes are normal.
- Arbitration: each cycle, grant the lowest-index valid buffer (load > FPU > ALU).
  - Granted buffer is cleared at the edge, unless the same source hands over a new result that edge, in which case it reloads (back-to-back, no bubble).
- Output register at each edge:
  - If any grant: wb_we=1 and wb_rd/wb_f/wb_data take the granted fields.
  - Else: wb_we=0; wb_rd/wb_f/wb_data hold their previous values.
- Latency: a handshake at edge E gives wb_we=1 after edge E+1 when uncontested; the register file commits at edge E+2. A loser waits one extra cycle per higher-priority grant.
- Throughput: one write per cycle sustained. Each source sustains one result per cycle only while it keeps winning.
- Simultaneous events:
  - All three accepts in the same edge → written on three consecutive cycles in order load, FPU, ALU.
  - A new handshake into a buffer that is valid and not granted cannot occur (ready=0).
- wb_busy = OR of buffer valids (registered state only).
- Ordering: no two in-flight results target the same (rd, f). The upstream scoreboard guarantees this; the arbiter performs no same-destination reordering check.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined:
  - Each buffer has a 4-bit wait counter. It increments each cycle the buffer is valid but not granted, clears on grant or reset, and saturates at 15.
  - A buffer whose counter ≥ STARVE_LIMIT is granted ahead of fixed priority.
  - Among several starved buffers, the lowest index wins.
- Undefined: pure fixed priority, no counters; the ALU can starve indefinitely under continuous load/FPU traffic.

Test Plan:
- Reset, then ALU handshake rd=5, f=0, data=0x1234 at edge E → wb_we=1, wb_rd=5, wb_f=0, wb_data=0x1234 after E+1; wb_we=0 after E+2.
- Load (rd=1, 0xA), FPU (rd=2, f=1, 0xB) and ALU (rd=3, 0xC) handshake the same edge → writes rd1, f2, rd3 on three consecutive cycles; ALU src_ready=0 for the two cycles in between.
- ALU rd=0, f=0, data=0xFFFF → accepted, wb_we never asserts. FPU rd=0, f=1 → wb_we=1, wb_rd=0, wb_f=1.
- ALU valid every cycle for 6 cycles, values 1..6, no other traffic → six consecutive wb_we=1 cycles with data 1..6 and src_ready[2] constantly 1.
- Two results pending, rst pulsed for 1 cycle → wb_we=0 and wb_busy=0 after the reset edge; neither result ever written.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=8, load valid every cycle while the ALU has one pending result → ALU granted on the 9th cycle of waiting. Without the macro, the ALU is never granted while load traffic continues.
